// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, frame marker and loader state encoding
package imem_loader_pkg;
    localparam int         WIDTH         = 32;
    localparam int         REG_ADDR_LEN  = 5;
    localparam int         IMEM_ADDR_LEN = 10;
    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte link, instruction-memory write port and CPU control
interface imem_loader_if #(
    parameter int WIDTH         = imem_loader_pkg::WIDTH,
    parameter int IMEM_ADDR_LEN = imem_loader_pkg::IMEM_ADDR_LEN
);
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     imem_wr_en;
    logic [IMEM_ADDR_LEN-1:0] imem_wr_addr;
    logic [WIDTH-1:0]         imem_wr_data;
    logic                     cpu_rst_n;
    logic                     cpu_halt;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [15:0]              words_loaded;
    modport slave (
        input  in_data, in_valid, cpu_halt,
        output in_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
               cpu_rst_n, busy, done, err, words_loaded
    );
    modport master (
        output in_data, in_valid, cpu_halt,
        input  in_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
               cpu_rst_n, busy, done, err, words_loaded
    );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// byte_word_packer: assembles big-endian 32-bit words from bytes and keeps a running XOR
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  xor_acc
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  xor_q, xor_d;
    // byte position, partial word and checksum advance on each payload byte
    always_comb begin
        cnt_d   = clr ? 2'd0 : byte_valid ? cnt_q + 2'd1 : cnt_q;
        shift_d = clr ? 24'd0 : byte_valid ? {shift_q[15:0], byte_in} : shift_q;
        xor_d   = clr ? 8'd0 : byte_valid ? xor_q ^ byte_in : xor_q;
    end
    // packer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
            xor_q   <= 8'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            xor_q   <= xor_d;
        end
    end
    assign word_valid = byte_valid && !clr && cnt_q == 2'd3;
    assign word       = {shift_q, byte_in};
    assign xor_acc    = xor_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for instruction memory with CPU reset control
module imem_loader #(
    parameter int         WIDTH         = imem_loader_pkg::WIDTH,
    parameter int         IMEM_ADDR_LEN = imem_loader_pkg::IMEM_ADDR_LEN,
    parameter logic [7:0] SYNC_BYTE     = imem_loader_pkg::SYNC_BYTE
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    import imem_loader_pkg::*;
    localparam logic [16:0] DEPTH = 17'(1) << IMEM_ADDR_LEN;
    logic [2:0]               state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [15:0]              words_q, words_d;
    logic [IMEM_ADDR_LEN-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]         data_q, data_d;
    logic wr_en_q, wr_en_d;
    logic in_ready_q, in_ready_d;
    logic cpu_rst_n_q, cpu_rst_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic        accept, is_sync, clr, pk_valid, word_valid;
    logic [31:0] word;
    logic [7:0]  xor_acc;
    assign accept   = bus.in_valid && in_ready_q;
    assign is_sync  = bus.in_data == SYNC_BYTE;
    assign pk_valid = accept && state_q == S_DATA;
    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_valid (pk_valid),
        .byte_in    (bus.in_data),
        .word_valid (word_valid),
        .word       (word),
        .xor_acc    (xor_acc)
    );
    // frame sequencing: length capture, payload, checksum, CPU run and halt
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: if (accept && is_sync) begin
                state_d = S_LEN_HI;
                clr     = 1'b1;
            end
            S_LEN_HI: if (accept) begin
                len_d   = {bus.in_data, 8'h00};
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (accept) begin
                len_d   = {len_q[15:8], bus.in_data};
                state_d = ({1'b0, len_d} > DEPTH) ? S_ERROR : (len_d == 16'd0) ? S_CHECK : S_DATA;
            end
            S_DATA:  state_d = (word_valid && words_q + 16'd1 == len_q) ? S_CHECK : S_DATA;
            S_CHECK: if (accept) state_d = (bus.in_data == xor_acc) ? S_RUN : S_ERROR;
            S_RUN:   state_d = bus.cpu_halt ? S_HALTED : S_RUN;
            default: state_d = state_q;
        endcase
    end
    // write port, word counter and status levels follow the next state so they are registered
    always_comb begin
        words_d     = clr ? 16'd0 : word_valid ? words_q + 16'd1 : words_q;
        addr_d      = clr ? '0 : word_valid ? words_q[IMEM_ADDR_LEN-1:0] : addr_q;
        data_d      = word_valid ? word : data_q;
        wr_en_d     = word_valid;
        in_ready_d  = state_d != S_RUN;
        cpu_rst_n_d = state_d == S_RUN || state_d == S_HALTED;
        busy_d      = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
        done_d      = state_d == S_HALTED;
        err_d       = state_d == S_ERROR;
    end
    // state and output registers; reset holds the CPU in reset immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            words_q     <= 16'd0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            in_ready_q  <= in_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
    assign bus.in_ready     = in_ready_q;
    assign bus.imem_wr_en   = wr_en_q;
    assign bus.imem_wr_addr = addr_q;
    assign bus.imem_wr_data = data_q;
    assign bus.cpu_rst_n    = cpu_rst_n_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = words_q;
endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side program loader that acts as the writer for the CPU's instruction memory. It accepts a framed byte stream, assembles 32-bit big-endian words and writes them to instruction memory from address 0 upward while holding the CPU in reset. After a valid checksum it releases the CPU and watches `halt` to report completion. It sits beside the CPU top, between a host byte link and the instruction-memory write port and CPU reset.

## Interface
Parameters:
- `WIDTH`, 32: instruction word width; must be 32.
- `IMEM_ADDR_LEN`, 10: instruction-memory word-address width; depth = 2^IMEM_ADDR_LEN.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 8: host byte.
- `in_valid` in 1: host byte present.
- `in_ready` out 1: loader accepts a byte. A transfer occurs when `in_valid && in_ready`.
- `imem_wr_en` out 1: one-cycle write strobe.
- `imem_wr_addr` out IMEM_ADDR_LEN: word address.
- `imem_wr_data` out WIDTH: word to write.
- `cpu_rst_n` out 1: drives CPU `rst_n`; low holds the CPU in reset.
- `cpu_halt` in 1: CPU `halt`.
- `busy` out 1: a frame is in progress.
- `done` out 1: CPU has halted after a good load.
- `err` out 1: the last frame was rejected.
- `words_loaded` out 16: count of words written in the current or last frame.

## Operation
- Frame format: SYNC, N[15:8], N[7:0], then N×4 payload bytes (MSB first per word), then CHK. CHK is the XOR of all payload bytes; SYNC and N are excluded from CHK.
- States and transitions:
  - IDLE → LEN_HI on SYNC. Any other byte is accepted and dropped.
  - LEN_HI → LEN_LO.
  - LEN_LO:
    - N > 2^IMEM_ADDR_LEN → ERROR.
    - N = 0 → CHECK.
    - Otherwise → DATA.
  - DATA: collect bytes. On every 4th byte, issue a write; after word N → CHECK.
  - CHECK: compare the byte against the running XOR. Match → RUN; mismatch → ERROR.
  - RUN: `in_ready` = 0. When `cpu_halt` = 1 → HALTED.
  - HALTED, ERROR: a SYNC byte starts a new frame (→ LEN_HI). Other bytes are dropped.
- Starting a new frame:
  - Clears `words_loaded`, `err`, `done`, the XOR accumulator and the byte-in-word counter.
  - Drives `cpu_rst_n` low.
- `in_ready` = 1 in every state except RUN.
- `imem_wr_addr` starts at 0 and increments by 1 per write, with no wrap. The N bound guarantees addresses never exceed depth-1.
- Output levels:
  - `busy` = 1 in LEN_HI, LEN_LO, DATA and CHECK.
  - `done` = 1 in HALTED.
  - `err` = 1 in ERROR.
- A SYNC byte inside DATA is treated as payload. There is no resynchronisation mid-frame.
- `cpu_halt` is ignored in every state except RUN.

## Timing
- Reset values:
  - state = IDLE, `in_ready` = 1, `imem_wr_en` = 0, `imem_wr_addr` = 0, `imem_wr_data` = 0.
  - `cpu_rst_n` = 0, `busy` = 0, `done` = 0, `err` = 0, `words_loaded` = 0.
- All outputs are registered.
- Write latency: `imem_wr_en` is high exactly one cycle, in the cycle after the 4th byte of a word is accepted, with the matching addr/data. `words_loaded` increments in that same cycle.
- Back-to-back bytes (one per cycle) are sustained without stall, giving at most one write per 4 cycles.
- `cpu_rst_n` rises the cycle after CHECK accepts a matching CHK. It stays high in RUN and HALTED. It falls the cycle after a new SYNC is accepted.
- HALTED is entered the cycle after `cpu_halt` is sampled high in RUN, so `done` rises 1 cycle after `cpu_halt`.
- `rst` asserted mid-frame: immediate return to reset values. `cpu_rst_n` is forced low asynchronously. Partially written memory is left as is.

## Structure
- The shared parameters file holds:
  - `SYNC_BYTE`.
  - The state encoding: IDLE, LEN_HI, LEN_LO, DATA, CHECK, RUN, HALTED, ERROR.
  - `IMEM_ADDR_LEN`, alongside the existing `WIDTH` and `REG_ADDR_LEN` defines.
- One natural sub-module, `byte_word_packer`: byte-in-word counter, shift register and XOR accumulator. It emits `word_valid` and `word` with a clear input.
- The FSM, address counter and CPU-control logic stay in `imem_loader`.

## Test plan
- Good load: A5 00 02 11 22 33 44 55 66 77 88 CHK=0x88, back-to-back.
  - Writes 0x11223344 @0 and 0x55667788 @1, each a one-cycle strobe.
  - `cpu_rst_n` rises 1 cycle after CHK.
  - `cpu_halt` pulsed 20 cycles later → `done` = 1 after 1 cycle.
- Bad checksum: same frame with CHK=0x00.
  - Both writes occur; `err` = 1; `cpu_rst_n` stays 0; `words_loaded` = 2.
- Oversize length: N = 0x0401 with IMEM_ADDR_LEN = 10.
  - ERROR right after LEN_LO; no writes.
  - A following good frame loads normally.
- Empty frame and noise: bytes 00 FF, then A5 00 00 00.
  - Noise is dropped; no writes; CPU released.
- Throttling and reset: `in_valid` toggled randomly during DATA gives the same words as the good load. Asserting `rst` after 5 payload bytes gives all outputs at reset values the same cycle, and the next frame writes from address 0.
